// File: rtl/world_clock_pkg.sv
// Shared types and constants for the world-time counter: field limits,
// timezone defaults, the two-digit BCD struct and its binary converter.
package world_clock_pkg;

   localparam logic [5:0] SEC_MAX = 6'd59;
   localparam logic [5:0] MIN_MAX = 6'd59;
   localparam logic [4:0] HR_MAX  = 5'd23;

   localparam int TZ_MIN_DEFAULT = -12;
   localparam int TZ_MAX_DEFAULT = 14;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd2_t;

   typedef logic signed [5:0] tz_t;

   // Ones digit is taken modulo 16 from the low nibble: (bin - 10*tens) < 10,
   // so subtracting (10*tens mod 16) from bin[3:0] yields it exactly.
   function automatic bcd2_t to_bcd2(input logic [5:0] bin);
      bcd2_t r;
      if (bin >= 6'd50) begin
         r.tens = 4'd5;
         r.ones = bin[3:0] - 4'd2;
      end else if (bin >= 6'd40) begin
         r.tens = 4'd4;
         r.ones = bin[3:0] - 4'd8;
      end else if (bin >= 6'd30) begin
         r.tens = 4'd3;
         r.ones = bin[3:0] - 4'd14;
      end else if (bin >= 6'd20) begin
         r.tens = 4'd2;
         r.ones = bin[3:0] - 4'd4;
      end else if (bin >= 6'd10) begin
         r.tens = 4'd1;
         r.ones = bin[3:0] - 4'd10;
      end else begin
         r.tens = 4'd0;
         r.ones = bin[3:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/bin_to_bcd2.sv
// Combinational 0..59 binary to two-digit BCD converter.
module bin_to_bcd2
   import world_clock_pkg::*;
(
   input  logic [5:0] bin,
   output bcd2_t      bcd
);

   assign bcd = to_bcd2(bin);

endmodule

// File: rtl/world_time_counter.sv
// UTC hh:mm:ss counter advanced by divider toggle edges, with button setting
// and a signed timezone offset producing registered local-time BCD fields.
module world_time_counter
   import world_clock_pkg::*;
#(
   parameter int TZ_MIN    = TZ_MIN_DEFAULT,
   parameter int TZ_MAX    = TZ_MAX_DEFAULT,
   parameter int INIT_HOUR = 0
) (
   input  logic       clk100hz,
   input  logic       reset_n,
   input  logic       clk1hz_in,
   input  logic       set_en,
   input  logic       inc_hr,
   input  logic       inc_min,
   input  logic [5:0] tz_offset,
   output logic [7:0] hr_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic [1:0] day_delta,
   output logic       day_tick
);

   localparam tz_t        TZ_LO       = tz_t'(TZ_MIN);
   localparam tz_t        TZ_HI       = tz_t'(TZ_MAX);
   localparam logic [4:0] INIT_HR     = INIT_HOUR[4:0];
   localparam bcd2_t      INIT_HR_BCD = to_bcd2({1'b0, INIT_HR});

   logic              clk1hz_q;
   logic              tick;
   logic [5:0]        sec_q, sec_d;
   logic [5:0]        min_q, min_d;
   logic [4:0]        hr_q, hr_d;
   logic              day_tick_q, day_tick_d;
   bcd2_t             hr_bcd_q, hr_bcd_d;
   bcd2_t             min_bcd_q, min_bcd_d;
   bcd2_t             sec_bcd_q, sec_bcd_d;
   logic [1:0]        day_delta_q, day_delta_d;
   tz_t               tz_s;
   tz_t               tz_eff;
   logic signed [6:0] local_raw;
   logic [5:0]        local_hr;
   bcd2_t             hr_conv, min_conv, sec_conv;

   // Divider output shares this clock, so a plain edge compare is safe.
   assign tick = clk1hz_in ^ clk1hz_q;

   always_comb begin
      sec_d      = sec_q;
      min_d      = min_q;
      hr_d       = hr_q;
      day_tick_d = 1'b0;
      if (set_en) begin
         sec_d = 6'd0;
         if (inc_min) begin
            min_d = (min_q == MIN_MAX) ? 6'd0 : min_q + 6'd1;
         end else begin
            min_d = min_q;
         end
         if (inc_hr) begin
            hr_d = (hr_q == HR_MAX) ? 5'd0 : hr_q + 5'd1;
         end else begin
            hr_d = hr_q;
         end
      end else if (tick) begin
         if (sec_q == SEC_MAX) begin
            sec_d = 6'd0;
            if (min_q == MIN_MAX) begin
               min_d = 6'd0;
               if (hr_q == HR_MAX) begin
                  hr_d       = 5'd0;
                  day_tick_d = 1'b1;
               end else begin
                  hr_d = hr_q + 5'd1;
               end
            end else begin
               min_d = min_q + 6'd1;
            end
         end else begin
            sec_d = sec_q + 6'd1;
         end
      end else begin
         sec_d = sec_q;
      end
   end

   // Seven bits: 23 + 14 would overflow a 6-bit signed sum.
   assign tz_s      = tz_t'(tz_offset);
   assign tz_eff    = ((tz_s >= TZ_LO) && (tz_s <= TZ_HI)) ? tz_s : 6'sd0;
   assign local_raw = $signed({2'b00, hr_q}) + $signed({tz_eff[5], tz_eff});

   always_comb begin
      local_hr    = local_raw[5:0];
      day_delta_d = 2'b00;
      if (local_raw < 7'sd0) begin
         local_hr    = 6'(local_raw + 7'sd24);
         day_delta_d = 2'b11;
      end else if (local_raw >= 7'sd24) begin
         local_hr    = 6'(local_raw - 7'sd24);
         day_delta_d = 2'b01;
      end else begin
         local_hr    = local_raw[5:0];
         day_delta_d = 2'b00;
      end
   end

   bin_to_bcd2 u_hr_bcd  (.bin(local_hr), .bcd(hr_conv));
   bin_to_bcd2 u_min_bcd (.bin(min_q),    .bcd(min_conv));
   bin_to_bcd2 u_sec_bcd (.bin(sec_q),    .bcd(sec_conv));

   always_comb begin
      hr_bcd_d  = hr_conv;
      min_bcd_d = min_conv;
      sec_bcd_d = sec_conv;
   end

   always_ff @(posedge clk100hz or negedge reset_n) begin
      if (!reset_n) begin
         clk1hz_q    <= 1'b0;
         sec_q       <= 6'd0;
         min_q       <= 6'd0;
         hr_q        <= INIT_HR;
         day_tick_q  <= 1'b0;
         hr_bcd_q    <= INIT_HR_BCD;
         min_bcd_q   <= 8'h00;
         sec_bcd_q   <= 8'h00;
         day_delta_q <= 2'b00;
      end else begin
         clk1hz_q    <= clk1hz_in;
         sec_q       <= sec_d;
         min_q       <= min_d;
         hr_q        <= hr_d;
         day_tick_q  <= day_tick_d;
         hr_bcd_q    <= hr_bcd_d;
         min_bcd_q   <= min_bcd_d;
         sec_bcd_q   <= sec_bcd_d;
         day_delta_q <= day_delta_d;
      end
   end

   assign hr_bcd    = hr_bcd_q;
   assign min_bcd   = min_bcd_q;
   assign sec_bcd   = sec_bcd_q;
   assign day_delta = day_delta_q;
   assign day_tick  = day_tick_q;

endmodule
